// File: rtl/qs_fifo_reader.sv
// qs_fifo_reader: drains a qs_fifo-style pop interface into a valid/ready
// stream. Words are grouped into BURST_LEN-word bursts tagged with m_last_o.
// A 2-entry output buffer keeps pop_o independent of m_ready_i, and a burst
// that has started is always completed before the engine goes idle.
module qs_fifo_reader #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] pop_data_i,
  output logic              pop_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t             state_q;
  logic [1:0]         occ_q, occ_d;
  logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
  logic [DATA_W-1:0]  data0_q, data0_d, data1_q, data1_d;
  logic               last0_q, last0_d, last1_q, last1_d;

  logic               pop_en_s;
  logic               pop_s;
  logic               beat_s;
  logic               tag_last_s;
  logic               boundary_s;

  // Pops are qualified only by registered state/occupancy and the FIFO flag.
  assign pop_en_s   = (state_q == ST_RUN) || (state_q == ST_FINISH);
  assign pop_s      = pop_en_s && !empty_i && (occ_q != 2'd2);
  assign beat_s     = (occ_q != 2'd0) && m_ready_i;
  assign tag_last_s = (pop_cnt_q == CNT_W'(BURST_LEN - 1));
  // True when the burst counter will sit on a burst boundary after this edge.
  assign boundary_s = pop_s ? tag_last_s : (pop_cnt_q == '0);

  assign pop_o     = pop_s;
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = data0_q;
  assign m_last_o  = last0_q;
  assign busy_o    = (state_q != ST_IDLE) || (occ_q != 2'd0);

  // Next buffer contents, occupancy and burst position from pop/beat events.
  always_comb begin
    occ_d     = occ_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    last0_d   = last0_q;
    last1_d   = last1_q;
    pop_cnt_d = pop_cnt_q;
    case ({pop_s, beat_s})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          data0_d = pop_data_i;
          last0_d = tag_last_s;
        end else begin
          data1_d = pop_data_i;
          last1_d = tag_last_s;
        end
      end
      2'b01: begin
        occ_d   = occ_q - 2'd1;
        data0_d = data1_q;
        last0_d = last1_q;
      end
      2'b11: begin
        // Beat frees the head while the pop refills it (occupancy was 1).
        data0_d = pop_data_i;
        last0_d = tag_last_s;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
    if (pop_s) begin
      if (tag_last_s) begin
        pop_cnt_d = '0;
      end else begin
        pop_cnt_d = pop_cnt_q + CNT_W'(1);
      end
    end else begin
      pop_cnt_d = pop_cnt_q;
    end
  end

  // Datapath registers: buffer entries, occupancy and burst counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q     <= 2'd0;
      pop_cnt_q <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      pop_cnt_q <= pop_cnt_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      last0_q   <= last0_d;
      last1_q   <= last1_d;
    end
  end

  // Control FSM: run while enabled, finish the open burst, then drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) state_q <= ST_RUN;
          else          state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (enable_i)        state_q <= ST_RUN;
          else if (boundary_s) state_q <= ST_DRAIN;
          else                 state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          if (pop_s && tag_last_s) state_q <= ST_DRAIN;
          else                     state_q <= ST_FINISH;
        end
        ST_DRAIN: begin
          if (occ_d == 2'd0) state_q <= ST_IDLE;
          else               state_q <= ST_DRAIN;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
